// File: rtl/coherence_bus_ctrl_if.sv
// Signal bundle between two caches, the coherence bus controller and RAM.
// Packed [1:0] / [1:0][31:0] fields are indexed by CPU id.
interface coherence_bus_ctrl_if;
   logic [1:0]       iREN;
   logic [1:0]       dREN;
   logic [1:0]       dWEN;
   logic [1:0][31:0] iaddr;
   logic [1:0][31:0] daddr;
   logic [1:0][31:0] dstore;
   logic [1:0]       ccwrite;
   logic [1:0]       cctrans;
   logic [31:0]      ramload;
   logic [1:0]       ramstate;
   logic [1:0]       iwait;
   logic [1:0]       dwait;
   logic [1:0][31:0] iload;
   logic [1:0][31:0] dload;
   logic [31:0]      ramaddr;
   logic [31:0]      ramstore;
   logic             ramREN;
   logic             ramWEN;
   logic [1:0]       ccwait;
   logic [1:0]       ccinv;
   logic [1:0][31:0] ccsnoopaddr;

   modport slave (
      input  iREN, dREN, dWEN, iaddr, daddr, dstore, ccwrite, cctrans, ramload, ramstate,
      output iwait, dwait, iload, dload, ramaddr, ramstore, ramREN, ramWEN, ccwait, ccinv,
             ccsnoopaddr
   );

   modport master (
      output iREN, dREN, dWEN, iaddr, daddr, dstore, ccwrite, cctrans, ramload, ramstate,
      input  iwait, dwait, iload, dload, ramaddr, ramstore, ramREN, ramWEN, ccwait, ccinv,
             ccsnoopaddr
   );
endinterface

// File: rtl/coherence_bus_ctrl.sv
// Two-CPU snooping coherence bus controller: arbitrates cache requests onto one RAM port,
// one transaction at a time, with cache-to-cache supply on snoop hits.
module coherence_bus_ctrl #(
   parameter int unsigned CPUS = 2
) (
   input logic                 CLK,
   input logic                 RST,
   coherence_bus_ctrl_if.slave bus_io
);

   if (CPUS != 2) begin : g_bad_cpus
      $error("coherence_bus_ctrl supports CPUS == 2 only");
   end

   typedef enum logic [2:0] {
      StIdle,
      StWb,
      StSnoop,
      StSupply,
      StLoad,
      StInv,
      StIfetch
   } state_e;

   localparam logic [1:0] RamAccess = 2'd2;

   state_e state_q;
   logic   dptr_q;
   logic   iptr_q;
   logic   req_q;
   logic   oth;
   logic   access;
   logic [1:0] upgrade;

   assign oth     = ~req_q;
   assign access  = (bus_io.ramstate == RamAccess);
   // Upgrades only count when the cache intends to write and is not also reading.
   assign upgrade = bus_io.cctrans & bus_io.ccwrite & ~bus_io.dREN;

   function automatic logic pick(logic [1:0] want, logic ptr);
      return want[ptr] ? ptr : ~ptr;
   endfunction

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= StIdle;
         dptr_q  <= 1'b0;
         iptr_q  <= 1'b0;
         req_q   <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (|bus_io.dWEN) begin
                  req_q   <= pick(bus_io.dWEN, dptr_q);
                  state_q <= StWb;
               end else if (|bus_io.dREN) begin
                  req_q   <= pick(bus_io.dREN, dptr_q);
                  state_q <= StSnoop;
               end else if (|upgrade) begin
                  req_q   <= pick(upgrade, dptr_q);
                  state_q <= StInv;
               end else if (|bus_io.iREN) begin
                  req_q   <= pick(bus_io.iREN, iptr_q);
                  state_q <= StIfetch;
               end
            end
            StSnoop: state_q <= bus_io.dWEN[oth] ? StSupply : StLoad;
            StWb, StSupply, StLoad: begin
               if (access) begin
                  dptr_q  <= oth;
                  state_q <= StIdle;
               end
            end
            StInv: begin
               dptr_q  <= oth;
               state_q <= StIdle;
            end
            StIfetch: begin
               if (access) begin
                  iptr_q  <= oth;
                  state_q <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   logic [1:0]       iwait;
   logic [1:0]       dwait;
   logic [1:0][31:0] iload;
   logic [1:0][31:0] dload;
   logic [31:0]      ramaddr;
   logic [31:0]      ramstore;
   logic             ramREN;
   logic             ramWEN;
   logic [1:0]       ccwait;
   logic [1:0]       ccinv;
   logic [1:0][31:0] ccsnoopaddr;

   // Completion handshakes follow ramstate combinationally so a transfer retires on ACCESS.
   always_comb begin
      iwait       = 2'b11;
      dwait       = 2'b11;
      iload       = '0;
      dload       = '0;
      ramaddr     = '0;
      ramstore    = '0;
      ramREN      = 1'b0;
      ramWEN      = 1'b0;
      ccwait      = '0;
      ccinv       = '0;
      ccsnoopaddr = '0;
      unique case (state_q)
         StWb: begin
            ramWEN   = 1'b1;
            ramaddr  = bus_io.daddr[req_q];
            ramstore = bus_io.dstore[req_q];
            if (access) dwait[req_q] = 1'b0;
         end
         StSnoop: begin
            ccwait[oth]      = 1'b1;
            ccsnoopaddr[oth] = bus_io.daddr[req_q];
            ccinv[oth]       = bus_io.ccwrite[req_q];
         end
         StSupply: begin
            ccwait[oth]      = 1'b1;
            ccsnoopaddr[oth] = bus_io.daddr[req_q];
            ramWEN           = 1'b1;
            ramaddr          = bus_io.daddr[oth];
            ramstore         = bus_io.dstore[oth];
            dload[req_q]     = bus_io.dstore[oth];
            if (access) begin
               dwait[req_q] = 1'b0;
               dwait[oth]   = 1'b0;
            end
         end
         StLoad: begin
            ramREN       = 1'b1;
            ramaddr      = bus_io.daddr[req_q];
            dload[req_q] = bus_io.ramload;
            if (access) dwait[req_q] = 1'b0;
         end
         StInv: begin
            ccwait[oth]      = 1'b1;
            ccinv[oth]       = 1'b1;
            ccsnoopaddr[oth] = bus_io.daddr[req_q];
            dwait[req_q]     = 1'b0;
         end
         StIfetch: begin
            ramREN       = 1'b1;
            ramaddr      = bus_io.iaddr[req_q];
            iload[req_q] = bus_io.ramload;
            if (access) iwait[req_q] = 1'b0;
         end
         default: ;
      endcase
   end

   assign bus_io.iwait       = iwait;
   assign bus_io.dwait       = dwait;
   assign bus_io.iload       = iload;
   assign bus_io.dload       = dload;
   assign bus_io.ramaddr     = ramaddr;
   assign bus_io.ramstore    = ramstore;
   assign bus_io.ramREN      = ramREN;
   assign bus_io.ramWEN      = ramWEN;
   assign bus_io.ccwait      = ccwait;
   assign bus_io.ccinv       = ccinv;
   assign bus_io.ccsnoopaddr = ccsnoopaddr;

endmodule

// File: tb/tb_coherence_bus_ctrl.sv
// Bench for coherence_bus_ctrl: directed bus scenarios, then random traffic, all checked
// against a transaction-level model of the bus protocol.
module tb_coherence_bus_ctrl;

   logic CLK = 1'b0;
   logic RST;

   coherence_bus_ctrl_if bus ();

   coherence_bus_ctrl #(.CPUS(2)) dut (
      .CLK    (CLK),
      .RST    (RST),
      .bus_io (bus)
   );

   always #5 CLK = ~CLK;

   int unsigned checks = 0;
   int unsigned errors = 0;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Transaction-level model: what the bus is doing, for whom, and whose turn is next.
   typedef enum int {TxNone, TxWrite, TxRead, TxUpgrade, TxFetch} tx_kind_e;

   tx_kind_e m_kind;
   int       m_cpu;
   bit       m_snooped;
   bit       m_peer_has_line;
   int       m_dturn;
   int       m_iturn;

   typedef struct packed {
      logic [1:0]       iwait;
      logic [1:0]       dwait;
      logic [1:0]       ccwait;
      logic [1:0]       ccinv;
      logic             ren;
      logic             wen;
      logic [31:0]      addr;
      logic [31:0]      store;
      logic [1:0][31:0] iload;
      logic [1:0][31:0] dload;
      logic [1:0][31:0] snoop;
   } exp_t;

   function automatic int first_in_turn(input logic [1:0] want, input int turn);
      for (int k = 0; k < 2; k++) begin
         int c = (turn + k) % 2;
         if (want[c]) return c;
      end
      return 0;
   endfunction

   task automatic model_reset();
      m_kind  = TxNone;
      m_cpu   = 0;
      m_dturn = 0;
      m_iturn = 0;
   endtask

   task automatic model_expect(output exp_t e);
      bit ok;
      int peer;
      e       = '0;
      e.iwait = 2'b11;
      e.dwait = 2'b11;
      ok      = (bus.ramstate == 2'd2);
      peer    = 1 - m_cpu;
      case (m_kind)
         TxWrite: begin
            e.wen   = 1'b1;
            e.addr  = bus.daddr[m_cpu];
            e.store = bus.dstore[m_cpu];
            if (ok) e.dwait[m_cpu] = 1'b0;
         end
         TxRead: begin
            if (!m_snooped) begin
               e.ccwait[peer] = 1'b1;
               e.snoop[peer]  = bus.daddr[m_cpu];
               e.ccinv[peer]  = bus.ccwrite[m_cpu];
            end else if (m_peer_has_line) begin
               e.ccwait[peer] = 1'b1;
               e.snoop[peer]  = bus.daddr[m_cpu];
               e.wen          = 1'b1;
               e.addr         = bus.daddr[peer];
               e.store        = bus.dstore[peer];
               e.dload[m_cpu] = bus.dstore[peer];
               if (ok) e.dwait = 2'b00;
            end else begin
               e.ren          = 1'b1;
               e.addr         = bus.daddr[m_cpu];
               e.dload[m_cpu] = bus.ramload;
               if (ok) e.dwait[m_cpu] = 1'b0;
            end
         end
         TxUpgrade: begin
            e.ccwait[peer] = 1'b1;
            e.ccinv[peer]  = 1'b1;
            e.snoop[peer]  = bus.daddr[m_cpu];
            e.dwait[m_cpu] = 1'b0;
         end
         TxFetch: begin
            e.ren          = 1'b1;
            e.addr         = bus.iaddr[m_cpu];
            e.iload[m_cpu] = bus.ramload;
            if (ok) e.iwait[m_cpu] = 1'b0;
         end
         default: ;
      endcase
   endtask

   task automatic model_advance();
      bit ok;
      logic [1:0] upg;
      ok  = (bus.ramstate == 2'd2);
      upg = bus.cctrans & bus.ccwrite & ~bus.dREN;
      case (m_kind)
         TxNone: begin
            m_snooped = 1'b0;
            if (bus.dWEN != 0) begin
               m_kind = TxWrite;   m_cpu = first_in_turn(bus.dWEN, m_dturn);
            end else if (bus.dREN != 0) begin
               m_kind = TxRead;    m_cpu = first_in_turn(bus.dREN, m_dturn);
            end else if (upg != 0) begin
               m_kind = TxUpgrade; m_cpu = first_in_turn(upg, m_dturn);
            end else if (bus.iREN != 0) begin
               m_kind = TxFetch;   m_cpu = first_in_turn(bus.iREN, m_iturn);
            end
         end
         TxRead: begin
            if (!m_snooped) begin
               m_snooped       = 1'b1;
               m_peer_has_line = bus.dWEN[1 - m_cpu];
            end else if (ok) begin
               m_dturn = 1 - m_cpu; m_kind = TxNone;
            end
         end
         TxWrite:   if (ok) begin m_dturn = 1 - m_cpu; m_kind = TxNone; end
         TxUpgrade: begin m_dturn = 1 - m_cpu; m_kind = TxNone; end
         TxFetch:   if (ok) begin m_iturn = 1 - m_cpu; m_kind = TxNone; end
         default: m_kind = TxNone;
      endcase
   endtask

   task automatic check_cycle();
      exp_t e;
      #1;
      model_expect(e);
      check_eq("iwait", bus.iwait, e.iwait);
      check_eq("dwait", bus.dwait, e.dwait);
      check_eq("ramREN_WEN", {bus.ramREN, bus.ramWEN}, {e.ren, e.wen});
      check_eq("ramaddr", bus.ramaddr, e.addr);
      check_eq("ramstore", bus.ramstore, e.store);
      check_eq("ccwait", bus.ccwait, e.ccwait);
      check_eq("ccinv", bus.ccinv, e.ccinv);
      check_eq("ccsnoopaddr", bus.ccsnoopaddr, e.snoop);
      check_eq("iload", bus.iload, e.iload);
      check_eq("dload", bus.dload, e.dload);
   endtask

   task automatic advance();
      @(posedge CLK);
      if (!RST) model_advance();
      @(negedge CLK);
   endtask

   task automatic clear_inputs();
      bus.iREN = '0; bus.dREN = '0; bus.dWEN = '0;
      bus.iaddr = '0; bus.daddr = '0; bus.dstore = '0;
      bus.ccwrite = '0; bus.cctrans = '0;
      bus.ramload = '0; bus.ramstate = 2'd0;
   endtask

   task automatic rand_inputs();
      int r;
      for (int c = 0; c < 2; c++) begin
         bus.iREN[c]    = ($urandom_range(0, 3) == 0);
         bus.dREN[c]    = ($urandom_range(0, 3) == 0);
         bus.dWEN[c]    = ($urandom_range(0, 5) == 0);
         bus.ccwrite[c] = ($urandom_range(0, 1) == 0);
         bus.cctrans[c] = ($urandom_range(0, 3) == 0);
         bus.iaddr[c]   = $urandom;
         bus.daddr[c]   = $urandom;
         bus.dstore[c]  = $urandom;
      end
      bus.ramload = $urandom;
      r = $urandom_range(0, 5);
      bus.ramstate = (r > 3) ? 2'd2 : 2'(r);
   endtask

   // Asynchronous reset asserted mid-cycle; outputs must fall back to idle at once.
   task automatic pulse_reset();
      #2;
      RST = 1'b1;
      model_reset();
      check_cycle();
      check_eq("rst_dwait", bus.dwait, 2'b11);
      check_eq("rst_iwait", bus.iwait, 2'b11);
      @(posedge CLK);
      @(negedge CLK);
      RST = 1'b0;
   endtask

   initial begin
      RST = 1'b1;
      clear_inputs();
      model_reset();
      check_cycle();
      check_eq("reset_dwait", bus.dwait, 2'b11);
      @(negedge CLK);
      @(negedge CLK);
      RST = 1'b0;

      // Both CPUs fetch; CPU0 first after two BUSY cycles, then CPU1.
      bus.iREN = 2'b11; bus.iaddr[0] = 32'h100; bus.iaddr[1] = 32'h200;
      bus.ramstate = 2'd1; bus.ramload = 32'hCAFE0001;
      check_cycle(); advance();
      check_cycle(); advance();
      check_cycle(); advance();
      bus.ramstate = 2'd2;
      check_cycle();
      check_eq("fetch0_iwait", bus.iwait, 2'b10);
      check_eq("fetch0_iload", bus.iload[0], 32'hCAFE0001);
      check_eq("fetch0_addr", bus.ramaddr, 32'h100);
      advance();
      check_cycle(); advance();
      check_cycle();
      check_eq("fetch1_iwait", bus.iwait, 2'b01);
      check_eq("fetch1_addr", bus.ramaddr, 32'h200);
      advance();

      // CPU0 read hits a dirty line in CPU1, which supplies it.
      clear_inputs();
      bus.dREN = 2'b01; bus.daddr[0] = 32'h40;
      check_cycle(); advance();
      bus.dWEN = 2'b10; bus.daddr[1] = 32'h40; bus.dstore[1] = 32'hDEADBEEF;
      check_cycle();
      check_eq("snoop_ccwait", bus.ccwait, 2'b10);
      check_eq("snoop_addr", bus.ccsnoopaddr[1], 32'h40);
      advance();
      bus.ramstate = 2'd2;
      check_cycle();
      check_eq("supply_wen", bus.ramWEN, 1'b1);
      check_eq("supply_addr", bus.ramaddr, 32'h40);
      check_eq("supply_dload", bus.dload[0], 32'hDEADBEEF);
      check_eq("supply_dwait", bus.dwait, 2'b00);
      advance();

      // CPU1 read-for-write, no peer response: invalidating snoop then RAM load.
      clear_inputs();
      bus.dREN = 2'b10; bus.ccwrite = 2'b10; bus.daddr[1] = 32'h80; bus.ramstate = 2'd1;
      check_cycle(); advance();
      check_cycle();
      check_eq("rfw_ccinv", bus.ccinv, 2'b01);
      check_eq("rfw_snoop", bus.ccsnoopaddr[0], 32'h80);
      advance();
      check_cycle(); advance();
      bus.ramstate = 2'd2; bus.ramload = 32'h1234;
      check_cycle();
      check_eq("load_dwait", bus.dwait, 2'b01);
      check_eq("load_dload", bus.dload[1], 32'h1234);
      advance();

      // Upgrade by CPU0: single invalidate cycle, no RAM traffic.
      clear_inputs();
      bus.cctrans = 2'b01; bus.ccwrite = 2'b01; bus.daddr[0] = 32'h44; bus.ramstate = 2'd1;
      check_cycle(); advance();
      check_cycle();
      check_eq("inv_ccinv", bus.ccinv, 2'b10);
      check_eq("inv_snoop", bus.ccsnoopaddr[1], 32'h44);
      check_eq("inv_dwait", bus.dwait, 2'b10);
      check_eq("inv_noram", {bus.ramREN, bus.ramWEN}, 2'b00);
      advance();
      clear_inputs();
      check_cycle(); advance();

      // Writeback retried through ERROR, fetch served afterwards.
      bus.dWEN = 2'b01; bus.daddr[0] = 32'h10; bus.dstore[0] = 32'h55;
      bus.iREN = 2'b10; bus.iaddr[1] = 32'h300; bus.ramstate = 2'd3;
      check_cycle(); advance();
      for (int i = 0; i < 3; i++) begin
         check_cycle();
         check_eq("wb_err_dwait", bus.dwait, 2'b11);
         advance();
      end
      bus.ramstate = 2'd2;
      check_cycle();
      check_eq("wb_done_dwait", bus.dwait, 2'b10);
      advance();
      bus.dWEN = 2'b00;
      check_cycle(); advance();
      check_cycle();
      check_eq("wb_then_fetch", bus.ramaddr, 32'h300);
      check_eq("wb_then_fetch_iwait", bus.iwait, 2'b01);
      advance();

      // Reset in the middle of a load aborts it and rewinds the pointer.
      clear_inputs();
      bus.dREN = 2'b01; bus.daddr[0] = 32'h60; bus.ramstate = 2'd1;
      check_cycle(); advance();
      check_cycle(); advance();
      check_cycle();
      check_eq("pre_rst_ren", bus.ramREN, 1'b1);
      pulse_reset();
      bus.dREN = 2'b11; bus.daddr[1] = 32'h70;
      check_cycle(); advance();
      check_cycle();
      check_eq("post_rst_pick", bus.ccwait, 2'b10);
      advance();
      clear_inputs();
      bus.ramstate = 2'd2;
      check_cycle(); advance();
      check_cycle(); advance();

      for (int n = 0; n < 3000; n++) begin
         rand_inputs();
         if ($urandom_range(0, 79) == 0) begin
            pulse_reset();
         end else begin
            check_cycle();
            advance();
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
